uart_buffered_transmitter: RTL
==============================

Name: uart_buffered_transmitter

Overview:
- Host-facing UART transmit path for the console. Returns bytes such as key codes and status replies from terminal logic to the host.
- A byte FIFO with a valid/ready write port feeds a frame serializer and an integer-divisor baud tick generator.
- Frame format is set by parameters: 8 data bits LSB first, optional odd/even parity, 1 or 2 stop bits.
- Consecutive frames go out back-to-back with no idle gap while the FIFO holds data.

Parameters:
- CLK_FREQUENCY, 25000000: clk frequency in Hz.
- BAUD, 115200: line rate. DIV = (CLK_FREQUENCY + BAUD/2) / BAUD cycles per bit, computed at elaboration. Elaboration error if DIV < 2.
- FIFO_DEPTH, 16: byte entries. Must be a power of 2 and ≥ 2.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2. Any other value is an elaboration error.

Ports:
- clk  in  1  single clock. All logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  byte to transmit.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  FIFO can accept a byte. Combinational: !rst && fifo_count < FIFO_DEPTH.
- txd  out  1  serial line, registered, idles high.
- busy  out  1  serializer not in IDLE, registered.
- tx_done  out  1  one-cycle pulse at the end of each frame's last stop bit.
- fifo_count  out  log2(FIFO_DEPTH)+1  bytes currently stored in the FIFO.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: txd=1, busy=0, tx_done=0, fifo_count=0, FIFO pointers=0, state=IDLE, bit counter=0, baud counter=0.
- Reset mid-frame: the frame is abandoned and txd=1 on the first edge with rst high. FIFO contents are discarded. No tx_done pulse.
- Write handshake:
  - A byte is accepted on each edge where in_valid && in_ready.
  - When full, in_ready=0 and the byte is held by the source; it is never dropped and never overwrites.
  - A pop on the same edge does not make in_ready rise in that cycle, because in_ready depends on the registered count.
- Simultaneous push and pop: fifo_count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- Baud counter:
  - Counts 0..DIV-1. bit_end is asserted when it equals DIV-1, after which it reloads to 0.
  - It is held at 0 in IDLE and restarts at 0 on entering START.
  - Every bit lasts exactly DIV cycles.
- State machine (txd value is registered with each state):
  - IDLE, txd=1: if fifo_count != 0, pop the head into the shift register and go to START. This happens on the edge after the accept edge, so no FIFO bypass.
  - START, txd=0: on bit_end go to DATA with bit index 0.
  - DATA, txd=shift[0]: on bit_end shift right and increment the index. After index 7 go to PARITY if PARITY != 0, else STOP.
  - PARITY, txd=p: odd gives p = ~^byte; even gives p = ^byte. Parity is computed at pop and stored. On bit_end go to STOP.
  - STOP, txd=1: lasts STOP_BITS × DIV cycles. On the final bit_end, tx_done=1 for that cycle.
    - If the FIFO is non-empty: pop on the same edge and go to START (zero-gap back-to-back).
    - Otherwise go to IDLE.
- Latency: the start bit's first cycle on txd is the second rising edge after the accept edge when IDLE with an empty FIFO.
- Frame length is (1 + 8 + (PARITY != 0) + STOP_BITS) × DIV cycles.
- busy is high from the START entry edge through the last STOP cycle. It stays high continuously across back-to-back frames.
- in_valid with in_ready=0 has no effect. in_data is ignored unless accepted.

Test Plan:
- CLK_FREQUENCY=1000000, BAUD=100000 (DIV=10), PARITY=0, STOP_BITS=1; push 0x55 to an idle block -> txd low 2 edges after accept. txd then carries 0,1,0,1,0,1,0,1,0,1 at 10 cycles per bit. tx_done pulses at cycle 100 of the frame; busy=0 afterwards; fifo_count back to 0.
- PARITY=2: send 0x07 -> parity bit 1. PARITY=1: send 0x00 -> parity bit 1. PARITY=1: send 0xFF -> parity bit 1. Frame length is 110 cycles.
- STOP_BITS=2, send 0xA3 -> stop high for 20 cycles. Data bits read LSB first are 1,1,0,0,0,1,0,1.
- FIFO_DEPTH=4: hold in_valid high with bytes 0x01..0x06 -> 0x01 is popped at once. in_ready drops when fifo_count=4; no byte is lost. Output is 0x01..0x06 in order with no idle cycles between frames; busy stays high throughout; 6 tx_done pulses.
- At cycle 35 of a frame with 2 bytes queued, assert rst for 1 cycle -> txd=1 next edge, fifo_count=0, busy=0, no tx_done. A new byte after reset is sent correctly.
- With the FIFO full, a push is attempted on the same edge as a pop -> not accepted. fifo_count goes 4 to 3, then in_ready=1 the next cycle.

Source files
------------

// File: rtl/uart_buffered_transmitter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_buffered_transmitter: byte FIFO feeding a UART frame serializer     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module uart_buffered_transmitter #(
  parameter int CLK_FREQUENCY = 25000000,
  parameter int BAUD          = 115200,
  parameter int FIFO_DEPTH    = 16,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          txd,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV = (CLK_FREQUENCY + BAUD / 2) / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [AW:0]   DEPTH_L = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] DIV_M2  = CW'(DIV - 2);

  if (DIV < 2) begin : g_bad_div
    $error("uart_buffered_transmitter: DIV must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_buffered_transmitter: FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_buffered_transmitter: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_buffered_transmitter: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t          state;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [7:0]      shift;
  logic            par_bit;
  logic [2:0]      bit_idx;
  logic            stop_idx;
  logic [CW-1:0]   baud_cnt;

  logic            push;
  logic            pop;
  logic            bit_end;
  logic            last_stop;
  logic [7:0]      head;
  logic            head_par;

  // in_ready looks only at the registered count, so a pop cannot free a slot
  // for a push on the same edge.
  assign in_ready  = !rst && (fifo_count < DEPTH_L);
  assign push      = in_valid && in_ready;
  assign bit_end   = (baud_cnt == DIV_M1);
  assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx;
  assign head      = mem[rd_ptr];
  assign head_par  = (PARITY == 1) ? ~^head : ^head;
  assign pop       = (fifo_count != '0) &&
                     ((state == S_IDLE) || (state == S_STOP && bit_end && last_stop));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      txd      <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
      shift    <= '0;
      par_bit  <= 1'b0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      baud_cnt <= '0;
    end else begin
      // Raised one cycle early so the registered pulse lines up with the final stop cycle.
      tx_done <= (state == S_STOP) && last_stop && (baud_cnt == DIV_M2);
      if (pop) begin
        shift    <= head;
        par_bit  <= head_par;
        state    <= S_START;
        txd      <= 1'b0;
        busy     <= 1'b1;
        baud_cnt <= '0;
        bit_idx  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            baud_cnt <= '0;
            busy     <= 1'b0;
            txd      <= 1'b1;
          end
          S_START: begin
            if (bit_end) begin
              baud_cnt <= '0;
              state    <= S_DATA;
              txd      <= shift[0];
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end
          S_DATA: begin
            if (bit_end) begin
              baud_cnt <= '0;
              if (bit_idx == 3'd7) begin
                if (PARITY != 0) begin
                  state <= S_PARITY;
                  txd   <= par_bit;
                end else begin
                  state    <= S_STOP;
                  txd      <= 1'b1;
                  stop_idx <= 1'b0;
                end
              end else begin
                shift   <= shift >> 1;
                txd     <= shift[1];
                bit_idx <= bit_idx + 3'd1;
              end
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end
          S_PARITY: begin
            if (bit_end) begin
              baud_cnt <= '0;
              state    <= S_STOP;
              txd      <= 1'b1;
              stop_idx <= 1'b0;
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end
          S_STOP: begin
            if (bit_end) begin
              baud_cnt <= '0;
              if (last_stop) begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end else begin
                stop_idx <= 1'b1;
              end
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end
          default: begin
            state    <= S_IDLE;
            txd      <= 1'b1;
            busy     <= 1'b0;
            baud_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
